// File: rtl/instr_fetch_if.sv
// Load and fetch bus of the TIS-100 instruction store.
//   master : program loader / PC path side (drives load_* and Addr_instr)
//   slave  : instr_fetch side (drives load_ready, run, instr, instr_valid,
//            lastInstr, prog_len, parity_err)
// Bit ranges keep the original [0:n] (bit 0 = MSB) declaration order.
interface instr_fetch_if;
    logic        load_clr;
    logic        load_valid;
    logic        load_ready;
    logic [0:17] load_data;
    logic        load_last;
    logic [0:7]  Addr_instr;
    logic        run;
    logic [0:17] instr;
    logic        instr_valid;
    logic        lastInstr;
    logic [0:7]  prog_len;
    logic        parity_err;

    modport master (
        output load_clr, load_valid, load_data, load_last, Addr_instr,
        input  load_ready, run, instr, instr_valid, lastInstr, prog_len,
               parity_err
    );

    modport slave (
        input  load_clr, load_valid, load_data, load_last, Addr_instr,
        output load_ready, run, instr, instr_valid, lastInstr, prog_len,
               parity_err
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program store and fetch stage for a TIS-100 compute node.
// A program streams in over the load handshake (one word per cycle) and is
// held in an internal memory; once complete (RUN) the word at Addr_instr is
// returned with a one-cycle registered read, qualified by instr_valid and
// lastInstr.
// Ports:
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   bus.slave  : load_clr/load_valid/load_data/load_last/Addr_instr in,
//                load_ready/run/instr/instr_valid/lastInstr/prog_len/
//                parity_err out
// Parameters: DEPTH (1..256 slots), NOP_WORD (word for invalid fetches).
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and flag a sticky parity_err on a mismatching RUN fetch; otherwise
// parity_err is tied to 0.
module instr_fetch #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [17:0] NOP_WORD = 18'h0
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t      state;
    logic [7:0]  wr_ptr;
    // One bit wider than prog_len so DEPTH=256 still compares correctly.
    logic [8:0]  len_q;
    logic [17:0] instr_q;
    logic        valid_q;
    logic        last_q;

    logic [17:0] mem [DEPTH];

    logic [17:0] wdata;
    logic [17:0] rdata;
    logic [7:0]  addr;
    logic        clear;
    logic        xfer;
    logic        is_last;
    logic        in_range;
    logic        at_last;

    assign wdata    = bus.load_data;
    assign addr     = bus.Addr_instr;
    assign clear    = !rst_n || bus.load_clr;
    assign xfer     = bus.load_valid && (state != RUN);
    assign is_last  = bus.load_last || (wr_ptr == 8'(DEPTH - 1));
    assign in_range = ({1'b0, addr} < len_q);
    assign at_last  = ({1'b0, addr} == (len_q - 9'd1));
    // Only consumed when in_range, so addresses >= DEPTH never reach memory.
    assign rdata    = mem[addr[AW-1:0]];

    // Storage has no reset: a cleared program is discarded via len_q/state.
    always_ff @(posedge clk) begin
        if (!clear && xfer) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= EMPTY;
            wr_ptr  <= '0;
            len_q   <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (xfer) begin
                wr_ptr <= wr_ptr + 8'd1;
                if (is_last) begin
                    len_q <= {1'b0, wr_ptr} + 9'd1;
                    state <= RUN;
                end else begin
                    state <= LOAD;
                end
            end

            if (state == RUN) begin
                instr_q <= in_range ? rdata : NOP_WORD;
                valid_q <= in_range;
                last_q  <= at_last;
            end else begin
                instr_q <= NOP_WORD;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic perr_q;

    always_ff @(posedge clk) begin
        if (!clear && xfer) begin
            mem_par[wr_ptr[AW-1:0]] <= ^wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            perr_q <= 1'b0;
        end else if ((state == RUN) && in_range &&
                     ((^rdata) != mem_par[addr[AW-1:0]])) begin
            perr_q <= 1'b1;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.load_ready  = (state != RUN);
    assign bus.run         = (state == RUN);
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.lastInstr   = last_q;
    assign bus.prog_len    = len_q[7:0];
endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (DEPTH=16, NOP_WORD=0).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, i.e. they reflect the edge just taken.
module tb_instr_fetch;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    instr_fetch_if bus ();

    instr_fetch #(
        .DEPTH    (16),
        .NOP_WORD (18'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_clr   = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.Addr_instr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        total_cnt++; if (bus.load_ready !== 1'b1) $display("FAIL rst_load_ready got %b exp 1", bus.load_ready); else pass_cnt++;
        total_cnt++; if (bus.run !== 1'b0) $display("FAIL rst_run got %b exp 0", bus.run); else pass_cnt++;
        total_cnt++; if (bus.instr !== 18'h0) $display("FAIL rst_instr got %h exp 00000", bus.instr); else pass_cnt++;
        total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_instr_valid got %b exp 0", bus.instr_valid); else pass_cnt++;
        total_cnt++; if (bus.lastInstr !== 1'b0) $display("FAIL rst_lastInstr got %b exp 0", bus.lastInstr); else pass_cnt++;
        total_cnt++; if (bus.prog_len !== 8'd0) $display("FAIL rst_prog_len got %0d exp 0", bus.prog_len); else pass_cnt++;
        total_cnt++; if (bus.parity_err !== 1'b0) $display("FAIL rst_parity_err got %b exp 0", bus.parity_err); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load3();
        bus.load_valid = 1'b1;
        bus.load_data  = 18'h00001;
        bus.load_last  = 1'b0;
        step();
        total_cnt++; if (bus.load_ready !== 1'b1 || bus.run !== 1'b0) $display("FAIL load3_w1 ready/run got %b/%b exp 1/0", bus.load_ready, bus.run); else pass_cnt++;
        bus.load_data = 18'h00002;
        step();
        bus.load_data = 18'h00003;
        bus.load_last = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        total_cnt++; if (bus.run !== 1'b1) $display("FAIL load3_run got %b exp 1", bus.run); else pass_cnt++;
        total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL load3_ready got %b exp 0", bus.load_ready); else pass_cnt++;
        total_cnt++; if (bus.prog_len !== 8'd3) $display("FAIL load3_prog_len got %0d exp 3", bus.prog_len); else pass_cnt++;
        // First RUN cycle: fetch output not yet valid.
        total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL load3_first_valid got %b exp 0", bus.instr_valid); else pass_cnt++;
    endtask

    task automatic test_fetch();
        logic [17:0] exp_w [3];
        exp_w[0] = 18'h00001;
        exp_w[1] = 18'h00002;
        exp_w[2] = 18'h00003;
        for (int i = 0; i < 3; i++) begin
            bus.Addr_instr = 8'(i);
            step();
            total_cnt++; if (bus.instr !== exp_w[i]) $display("FAIL fetch_instr a=%0d got %h exp %h", i, bus.instr, exp_w[i]); else pass_cnt++;
            total_cnt++; if (bus.instr_valid !== 1'b1) $display("FAIL fetch_valid a=%0d got %b exp 1", i, bus.instr_valid); else pass_cnt++;
            total_cnt++; if (bus.lastInstr !== (i == 2)) $display("FAIL fetch_last a=%0d got %b exp %b", i, bus.lastInstr, (i == 2)); else pass_cnt++;
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] addrs [2];
        addrs[0] = 8'd5;
        addrs[1] = 8'd255;
        for (int i = 0; i < 2; i++) begin
            bus.Addr_instr = addrs[i];
            step();
            total_cnt++; if (bus.instr !== 18'h0 || bus.instr_valid !== 1'b0 || bus.lastInstr !== 1'b0)
                $display("FAIL oor a=%0d instr/valid/last got %h/%b/%b exp 00000/0/0", addrs[i], bus.instr, bus.instr_valid, bus.lastInstr);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_depth();
        bus.load_clr = 1'b1;
        step();
        bus.load_clr = 1'b0;
        total_cnt++; if (bus.run !== 1'b0 || bus.prog_len !== 8'd0 || bus.load_ready !== 1'b1)
            $display("FAIL clr_run run/len/ready got %b/%0d/%b exp 0/0/1", bus.run, bus.prog_len, bus.load_ready);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 18'h00100 + 18'(i);
            step();
            if (i == 14) begin
                total_cnt++; if (bus.run !== 1'b0 || bus.load_ready !== 1'b1) $display("FAIL full_w15 run/ready got %b/%b exp 0/1", bus.run, bus.load_ready); else pass_cnt++;
            end
        end
        total_cnt++; if (bus.run !== 1'b1 || bus.prog_len !== 8'd16) $display("FAIL full_w16 run/len got %b/%0d exp 1/16", bus.run, bus.prog_len); else pass_cnt++;
        // A 17th word is offered but must not be taken.
        bus.load_data = 18'h3ffff;
        total_cnt++; if (bus.load_ready !== 1'b0) $display("FAIL full_w17_ready got %b exp 0", bus.load_ready); else pass_cnt++;
        bus.Addr_instr = 8'd15;
        step();
        bus.load_valid = 1'b0;
        total_cnt++; if (bus.prog_len !== 8'd16) $display("FAIL full_w17_len got %0d exp 16", bus.prog_len); else pass_cnt++;
        total_cnt++; if (bus.instr !== 18'h0010f || bus.lastInstr !== 1'b1) $display("FAIL full_a15 instr/last got %h/%b exp 0010f/1", bus.instr, bus.lastInstr); else pass_cnt++;
        bus.Addr_instr = 8'd0;
        step();
        total_cnt++; if (bus.instr !== 18'h00100 || bus.lastInstr !== 1'b0) $display("FAIL full_a0 instr/last got %h/%b exp 00100/0", bus.instr, bus.lastInstr); else pass_cnt++;
        bus.Addr_instr = 8'd16;
        step();
        total_cnt++; if (bus.instr !== 18'h0 || bus.instr_valid !== 1'b0) $display("FAIL full_a16 instr/valid got %h/%b exp 00000/0", bus.instr, bus.instr_valid); else pass_cnt++;
    endtask

    task automatic test_clear_midload();
        bus.load_clr = 1'b1;
        step();
        bus.load_clr   = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 18'h0aaaa;
        step();
        bus.load_data = 18'h0bbbb;
        step();
        // Clear and a valid word in the same cycle: clear wins.
        bus.load_clr  = 1'b1;
        bus.load_data = 18'h0cccc;
        step();
        bus.load_clr   = 1'b0;
        bus.load_valid = 1'b0;
        total_cnt++; if (bus.prog_len !== 8'd0 || bus.load_ready !== 1'b1 || bus.run !== 1'b0)
            $display("FAIL clr_mid len/ready/run got %0d/%b/%b exp 0/1/0", bus.prog_len, bus.load_ready, bus.run);
        else pass_cnt++;
        step();
        total_cnt++; if (bus.run !== 1'b0) $display("FAIL clr_mid_hold run got %b exp 0", bus.run); else pass_cnt++;
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = 18'h2aaaa;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.Addr_instr = 8'd0;
        total_cnt++; if (bus.prog_len !== 8'd1 || bus.run !== 1'b1) $display("FAIL one_word len/run got %0d/%b exp 1/1", bus.prog_len, bus.run); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++; if (bus.instr !== 18'h2aaaa || bus.instr_valid !== 1'b1 || bus.lastInstr !== 1'b1)
                $display("FAIL one_word_fetch%0d instr/valid/last got %h/%b/%b exp 2aaaa/1/1", i, bus.instr, bus.instr_valid, bus.lastInstr);
            else pass_cnt++;
        end
        bus.Addr_instr = 8'd1;
        step();
        total_cnt++; if (bus.instr_valid !== 1'b0 || bus.lastInstr !== 1'b0) $display("FAIL one_word_a1 valid/last got %b/%b exp 0/0", bus.instr_valid, bus.lastInstr); else pass_cnt++;
        // Clear in RUN returns fetch outputs to their reset values.
        bus.Addr_instr = 8'd0;
        bus.load_clr   = 1'b1;
        step();
        bus.load_clr = 1'b0;
        total_cnt++; if (bus.instr !== 18'h0 || bus.instr_valid !== 1'b0 || bus.run !== 1'b0 || bus.prog_len !== 8'd0)
            $display("FAIL clr_in_run instr/valid/run/len got %h/%b/%b/%0d exp 00000/0/0/0", bus.instr, bus.instr_valid, bus.run, bus.prog_len);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = 18'h12345;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total_cnt++; if (bus.run !== 1'b0 || bus.prog_len !== 8'd0 || bus.instr !== 18'h0 || bus.load_ready !== 1'b1)
            $display("FAIL rst_in_run run/len/instr/ready got %b/%0d/%h/%b exp 0/0/00000/1", bus.run, bus.prog_len, bus.instr, bus.load_ready);
        else pass_cnt++;
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 18'(i + 1);
            bus.load_last  = (i == 2);
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.Addr_instr = 8'd0;
        step();
        total_cnt++; if (bus.parity_err !== 1'b0) $display("FAIL par_clean got %b exp 0", bus.parity_err); else pass_cnt++;
        dut.mem_par[1] <= ~dut.mem_par[1];
        bus.Addr_instr = 8'd1;
        step();
        total_cnt++; if (bus.parity_err !== 1'b1 || bus.instr !== 18'h00002) $display("FAIL par_flip err/instr got %b/%h exp 1/00002", bus.parity_err, bus.instr); else pass_cnt++;
        bus.Addr_instr = 8'd0;
        step();
        total_cnt++; if (bus.parity_err !== 1'b1) $display("FAIL par_sticky got %b exp 1", bus.parity_err); else pass_cnt++;
        bus.load_clr = 1'b1;
        step();
        bus.load_clr = 1'b0;
        total_cnt++; if (bus.parity_err !== 1'b0) $display("FAIL par_clr got %b exp 0", bus.parity_err); else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle_inputs();
        test_reset();
        test_load3();
        test_fetch();
        test_out_of_range();
        test_full_depth();
        test_clear_midload();
        test_reset_midrun();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
